// File: rtl/pw_pkg.sv
// Shared definitions for the password-sequence driver: state encoding,
// result codes, character width and buffer geometry.
package pw_pkg;

  localparam int CHAR_W    = 7;
  localparam int ADDR_W    = 4;
  localparam int DEPTH_DEF = 16;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ENTER = 3'd2,
    ST_GAP   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RES_TIMEOUT = 2'b00,
    RES_OPEN    = 2'b01,
    RES_WRONG   = 2'b10,
    RES_EARLY   = 2'b11
  } result_t;

  // Clamp a requested sequence length to the buffer depth.
  function automatic logic [4:0] clamp_len(input logic [4:0] req, input int depth);
    logic [4:0] lim;
    lim = 5'(depth);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/pw_char_buf.sv
// DEPTH x CHAR_W character register file: one synchronous write port,
// one combinational read port, asynchronous clear.
module pw_char_buf
  import pw_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CHAR_W-1:0] rdata
);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic              waddr_ok;
  logic              raddr_ok;

  // Addresses beyond the populated depth are silently dropped.
  assign waddr_ok = ({1'b0, waddr} < 5'(DEPTH));
  assign raddr_ok = ({1'b0, raddr} < 5'(DEPTH));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [CHAR_W-1:0] ent_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ent_reg <= '0;
        end else if (we && waddr_ok && (waddr == ADDR_W'(gi))) begin
          ent_reg <= wdata;
        end
      end

      assign mem[gi] = ent_reg;
    end
  endgenerate

  assign rdata = raddr_ok ? mem[raddr] : '0;

endmodule

// File: rtl/pw_driver.sv
// Plays a stored character sequence into a lock FSM (char + enter strobe),
// then waits for the lock's open/wrong verdict or a timeout.
module pw_driver
  import pw_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int HOLD_CYC  = 4,
  parameter int ENTER_CYC = 2,
  parameter int GAP_CYC   = 4,
  parameter int TIMEOUT   = 200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic [4:0]        len,
  input  logic              start,
  input  logic              open_in,
  input  logic              wrong_in,
  output logic [CHAR_W-1:0] char_out,
  output logic              enter_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [4:0]        len_reg, len_next;
  logic [CHAR_W-1:0] char_reg, char_next;
  result_t           result_reg, result_next;
  logic              enter_reg, busy_reg, done_reg;
  logic              load_char;
  logic              buf_we;
  logic [CHAR_W-1:0] buf_rdata;
  logic              last_char;

  // The buffer is only writable while no sequence is in flight.
  assign buf_we = wr_en && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  pw_char_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (buf_we),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr   (idx_next),
    .rdata   (buf_rdata)
  );

  assign last_char = ({1'b0, idx_reg} == (len_reg - 5'd1));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    len_next    = len_reg;
    result_next = result_reg;
    load_char   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cnt_next    = '0;
          result_next = RES_TIMEOUT;
          if (len == 5'd0) begin
            state_next = ST_WAIT;
          end else begin
            state_next = ST_SETUP;
            len_next   = clamp_len(len, DEPTH);
            idx_next   = '0;
            load_char  = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (open_in) begin
          state_next  = ST_DONE;
          result_next = RES_EARLY;
        end else if (cnt_reg == CNT_W'(HOLD_CYC - 1)) begin
          state_next = ST_ENTER;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_ENTER: begin
        if (open_in) begin
          state_next  = ST_DONE;
          result_next = RES_EARLY;
        end else if (cnt_reg == CNT_W'(ENTER_CYC - 1)) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_GAP: begin
        if (open_in) begin
          state_next  = ST_DONE;
          result_next = RES_EARLY;
        end else if (cnt_reg == CNT_W'(GAP_CYC - 1)) begin
          cnt_next = '0;
          if (last_char) begin
            state_next = ST_WAIT;
          end else begin
            state_next = ST_SETUP;
            idx_next   = idx_reg + 1'b1;
            load_char  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_WAIT: begin
        // open outranks wrong when both arrive together
        if (open_in) begin
          state_next  = ST_DONE;
          result_next = RES_OPEN;
        end else if (wrong_in) begin
          state_next  = ST_DONE;
          result_next = RES_WRONG;
        end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
          state_next  = ST_DONE;
          result_next = RES_TIMEOUT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    char_next = load_char ? buf_rdata : char_reg;
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      len_reg    <= '0;
      char_reg   <= '0;
      result_reg <= RES_TIMEOUT;
      enter_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      len_reg    <= len_next;
      char_reg   <= char_next;
      result_reg <= result_next;
      enter_reg  <= (state_next == ST_ENTER);
      busy_reg   <= (state_next != ST_IDLE);
      done_reg   <= (state_next == ST_DONE);
    end
  end

  assign char_out  = char_reg;
  assign enter_out = enter_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_pw_driver.sv
// Directed bench for pw_driver: a lock stand-in driven from the stimulus
// sequence, plus a monitor logging enter strobes and done pulses.
module tb_pw_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [6:0] wr_data = '0;
  logic [4:0] len = '0;
  logic       start = 1'b0;
  logic       open_in = 1'b0;
  logic       wrong_in = 1'b0;
  logic [6:0] char_out;
  logic       enter_out;
  logic       busy;
  logic       done;
  logic [1:0] result;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int n_rise = 0;
  int n_fall = 0;
  int n_done = 0;
  int done_cyc = 0;
  int rise_cyc [32];
  int fall_cyc [32];
  logic [6:0] rise_chr [32];
  logic enter_q = 1'b0;
  logic done_q = 1'b0;

  always #5 clk = ~clk;

  pw_driver dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .start     (start),
    .open_in   (open_in),
    .wrong_in  (wrong_in),
    .char_out  (char_out),
    .enter_out (enter_out),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // Monitor samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (enter_out && !enter_q) begin
      if (n_rise < 32) begin
        rise_cyc[n_rise] = cyc;
        rise_chr[n_rise] = char_out;
      end
      n_rise = n_rise + 1;
    end
    if (!enter_out && enter_q) begin
      if (n_fall < 32) fall_cyc[n_fall] = cyc;
      n_fall = n_fall + 1;
    end
    if (done && !done_q) begin
      done_cyc = cyc;
      n_done = n_done + 1;
    end
    enter_q = enter_out;
    done_q = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clr();
    n_rise = 0; n_fall = 0; n_done = 0;
  endtask

  task automatic wait_rise(input int k, input string tag);
    for (int i = 0; i < 400 && n_rise < k; i++) @(negedge clk);
    check(tag, 32'(n_rise >= k), 32'd1);
  endtask

  task automatic wait_fall(input int k, input string tag);
    for (int i = 0; i < 400 && n_fall < k; i++) @(negedge clk);
    check(tag, 32'(n_fall >= k), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600 && done !== 1'b1; i++) @(negedge clk);
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_char", 32'(char_out), 32'h0);
    check("rst_enter", 32'(enter_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(4'd0, 7'h41);
    wr(4'd1, 7'h42);
    wr(4'd2, 7'h43);

    // ABC, lock opens (wrong also asserted: open must win)
    clr();
    go(5'd3);
    check("t1_busy", 32'(busy), 32'h1);
    wait_fall(3, "t1_falls");
    cyc_n(4);
    open_in = 1'b1; wrong_in = 1'b1;
    wait_done("t1_done");
    open_in = 1'b0; wrong_in = 1'b0;
    check("t1_result", 32'(result), 32'h1);
    check("t1_nrise", 32'(n_rise), 32'd3);
    check("t1_space01", 32'(rise_cyc[1] - rise_cyc[0]), 32'd10);
    check("t1_space12", 32'(rise_cyc[2] - rise_cyc[1]), 32'd10);
    check("t1_width0", 32'(fall_cyc[0] - rise_cyc[0]), 32'd2);
    check("t1_width2", 32'(fall_cyc[2] - rise_cyc[2]), 32'd2);
    check("t1_chr0", 32'(rise_chr[0]), 32'h41);
    check("t1_chr1", 32'(rise_chr[1]), 32'h42);
    check("t1_chr2", 32'(rise_chr[2]), 32'h43);
    cyc_n(1);
    check("t1_done_low", 32'(done), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);
    check("t1_ndone", 32'(n_done), 32'd1);
    check("t1_char_hold", 32'(char_out), 32'h43);

    // Same sequence, lock reports wrong
    clr();
    go(5'd3);
    wait_fall(3, "t2_falls");
    cyc_n(4);
    wrong_in = 1'b1;
    wait_done("t2_done");
    wrong_in = 1'b0;
    check("t2_result", 32'(result), 32'h2);
    check("t2_busy_at_done", 32'(busy), 32'h1);
    cyc_n(1);
    check("t2_busy_after", 32'(busy), 32'h0);

    // No response: timeout
    clr();
    go(5'd3);
    wait_done("t3_done");
    check("t3_result", 32'(result), 32'h0);
    check("t3_latency", 32'(done_cyc - fall_cyc[2]), 32'd205);
    check("t3_ndone", 32'(n_done), 32'd1);
    cyc_n(1);

    // open during the second character's ENTER aborts
    clr();
    go(5'd3);
    wait_rise(2, "t4_rise2");
    check("t4_enter_hi", 32'(enter_out), 32'h1);
    open_in = 1'b1;
    cyc_n(1);
    open_in = 1'b0;
    check("t4_enter_drop", 32'(enter_out), 32'h0);
    check("t4_done", 32'(done), 32'h1);
    check("t4_result", 32'(result), 32'h3);
    cyc_n(30);
    check("t4_nrise", 32'(n_rise), 32'd2);
    check("t4_idle", 32'(busy), 32'h0);

    // Write and start while busy are ignored
    clr();
    go(5'd3);
    cyc_n(3);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 7'h7F;
    start = 1'b1; len = 5'd1;
    cyc_n(1);
    wr_en = 1'b0; start = 1'b0;
    wait_fall(3, "t6_falls");
    cyc_n(4);
    wrong_in = 1'b1;
    wait_done("t6_done");
    wrong_in = 1'b0;
    check("t6_result", 32'(result), 32'h2);
    check("t6_nrise", 32'(n_rise), 32'd3);
    check("t6_chr2", 32'(rise_chr[2]), 32'h43);
    cyc_n(1);
    go(5'd1);
    check("t6_entry0", 32'(char_out), 32'h41);
    open_in = 1'b1;
    cyc_n(1);
    open_in = 1'b0;
    check("t6_setup_abort", 32'(result), 32'h3);
    cyc_n(1);

    // Reset during GAP of character 2
    clr();
    go(5'd3);
    wait_fall(2, "t5_fall2");
    reset_n = 1'b0;
    #1;
    check("t5_char", 32'(char_out), 32'h0);
    check("t5_enter", 32'(enter_out), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_done", 32'(done), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    go(5'd1);
    check("t5_buf_clear", 32'(char_out), 32'h0);
    open_in = 1'b1;
    cyc_n(1);
    open_in = 1'b0;
    cyc_n(1);
    check("t5_nrise_abort", 32'(n_rise), 32'd2);
    go(5'd0);
    check("t5_wait_busy", 32'(busy), 32'h1);
    wait_done("t5_done");
    check("t5_result", 32'(result), 32'h0);
    check("t5_nrise", 32'(n_rise), 32'd2);
    cyc_n(1);

    // len above DEPTH clamps to 16 characters
    clr();
    go(5'd20);
    wait_done("t7_done");
    check("t7_result", 32'(result), 32'h0);
    check("t7_nrise", 32'(n_rise), 32'd16);
    cyc_n(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pw_driver.md
PW_DRIVER -- requirements
Module: pw_driver

Interface
REQ-001 Parameter DEPTH, default 16, number of 7-bit characters in the sequence buffer.
REQ-002 Parameter HOLD_CYC, default 4, cycles char_out is stable before enter_out rises.
REQ-003 Parameter ENTER_CYC, default 2, cycles enter_out is held high per character.
REQ-004 Parameter GAP_CYC, default 4, cycles enter_out is low after each character, with char_out unchanged.
REQ-005 Parameter TIMEOUT, default 200, maximum cycles to wait for a lock verdict after the last character.
REQ-006 clk  in  1  single clock for all logic; same domain as the lock FSM.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  buffer write strobe.
REQ-009 wr_addr  in  4  buffer write index.
REQ-010 wr_data  in  7  character to store.
REQ-011 len  in  5  sequence length, 0..16, sampled on start.
REQ-012 start  in  1  begin a sequence, level-sampled in IDLE.
REQ-013 open_in  in  1  lock open indicator, synchronous to clk.
REQ-014 wrong_in  in  1  lock wrong indicator, synchronous to clk.
REQ-015 char_out  out  7  character presented to the lock's char_in.
REQ-016 enter_out  out  1  enter strobe to the lock.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when result becomes valid.
REQ-019 result  out  2  00 timeout, 01 open, 10 wrong, 11 early-open; held until the next start.

Function
REQ-020 States SHALL be IDLE, SETUP, ENTER, GAP, WAIT, and DONE, with one cycle in DONE.
REQ-021 IDLE to SETUP when start=1 and len>0; captures len and sets idx=0.
REQ-022 IDLE to WAIT when start=1 and len=0.
REQ-023 SETUP drives char_out=buf[idx] and enter_out=0 for HOLD_CYC cycles, then goes to ENTER.
REQ-024 ENTER drives enter_out=1 for ENTER_CYC cycles, then goes to GAP.
REQ-025 GAP holds enter_out=0 for GAP_CYC cycles; if idx=len-1 it goes to WAIT, otherwise idx increments and it goes to SETUP.
REQ-026 char_out SHALL change only on entry to SETUP and SHALL otherwise hold its last value, including in IDLE.
REQ-027 WAIT counts cycles from 0; open_in=1 gives result 01, else wrong_in=1 gives 10, else reaching TIMEOUT gives 00; each then goes to DONE.
REQ-028 If open_in and wrong_in are both 1 in the same cycle, open SHALL take priority.
REQ-029 open_in=1 in SETUP, ENTER, or GAP SHALL abort the sequence: result 11, enter_out forced to 0 the next cycle, then DONE.
REQ-030 wrong_in during SETUP, ENTER, or GAP SHALL be ignored.
REQ-031 DONE pulses done=1 and returns to IDLE; start is not accepted in DONE.
REQ-032 A write with wr_en=1 in IDLE or DONE SHALL store wr_data at wr_addr in the same cycle.
REQ-033 wr_en while busy=1 SHALL be ignored.
REQ-034 wr_addr >= DEPTH SHALL be ignored.
REQ-035 start while busy SHALL be ignored.
REQ-036 len > DEPTH SHALL be clamped to DEPTH.
REQ-037 Phase and timeout counters SHALL be 8-bit and SHALL not wrap within one phase.

Reset
REQ-038 reset_n=0 asynchronously forces state=IDLE, char_out=0, enter_out=0, busy=0, done=0, result=00, idx=0, all counters 0, and all buffer entries 0.
REQ-039 Reset mid-sequence SHALL drop enter_out in the same cycle with no further strobes.
REQ-040 The block operates from the first clk edge after reset_n is released.

Structure
REQ-041 Shared package pw_pkg SHALL hold the state encoding, the result codes (RES_TIMEOUT, RES_OPEN, RES_WRONG, RES_EARLY), the 7-bit character width, and the DEPTH default.
REQ-042 Sub-module pw_char_buf SHALL implement the DEPTH x 7 register file: one synchronous write port, one combinational read port, and asynchronous clear.
REQ-043 The top-level lock test harness SHALL connect char_out and enter_out to the lock FSM's char_in and enter, and open and wrong back to open_in and wrong_in.

Verification
REQ-044 Write "ABC" (0x41,0x42,0x43), len=3, start; lock model asserts open 5 cycles after the third enter falls -> three enter pulses of 2 cycles each, spaced 10 cycles apart; result=01; one done pulse.
REQ-045 Same sequence; model asserts wrong_in -> result=10; busy falls one cycle after done.
REQ-046 Model never responds -> done exactly TIMEOUT+1 cycles after entering WAIT; result=00.
REQ-047 open_in pulsed during the second character's ENTER -> enter_out=0 next cycle; no third character sent; result=11.
REQ-048 reset_n low during GAP of character 2 -> all outputs 0 immediately; buffer reads 0; start with len=0 -> result=00 after timeout.
REQ-049 wr_en with wr_data=0x7F at address 0 while busy, and start while busy -> buffer entry 0 unchanged and the sequence in progress unaffected.
